pulpino_instr_fetch: RTL

//  AXI4 read master feeding the SPI loader of the PULPino system kernel. On a start pulse it reads

---
 rtl/pulpino_pkg.sv | 18 +
 rtl/pulpino_sync_fifo.sv | 58 +++++
 rtl/pulpino_instr_fetch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pulpino_pkg.sv
// Shared types and constants for the PULPino instruction-fetch path.
package pulpino_pkg;

  localparam int AXI_4K_BYTES = 4096;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN,
    FIN
  } fetch_state_t;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/pulpino_sync_fifo.sv
// Single-clock show-ahead FIFO: dout_o always shows the oldest stored word.
module pulpino_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem[rd_ptr_q];

  // A pop frees a slot this cycle, so push at full is allowed alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage write.
  // NOTE: the array has no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/pulpino_instr_fetch.sv
// AXI4 read master: fetches instr_num words in 4KB-safe bursts and streams them out.
module pulpino_instr_fetch #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_BURST_LEN        = 16,
  parameter int C_FIFO_DEPTH       = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ap_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [31:0]                   instr_num,
  output logic                          ap_done,
  output logic                          busy,
  output logic                          rlast_err,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,
  output logic                          word_tvalid,
  input  logic                          word_tready,
  output logic [31:0]                   word_tdata,
  output logic                          word_tlast
);

  import pulpino_pkg::*;

  localparam int CNT_W = $clog2(C_FIFO_DEPTH) + 1;

  fetch_state_t                  state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]                   words_left_q;
  logic [31:0]                   total_q;
  logic [31:0]                   word_idx_q;
  logic [31:0]                   len_q;
  logic [31:0]                   beat_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          rlast_err_q;

  logic [12:0]      bytes_to_4k;
  logic [31:0]      words_to_4k;
  logic [31:0]      len_c;
  logic [31:0]      free_slots;
  logic             credit_ok;
  logic             start_acc;
  logic             ar_hs;
  logic             r_hs;
  logic             at_last_pos;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      fifo_dout;

  assign start_acc   = ap_start && (state_q == IDLE) && !busy_q;
  assign ar_hs       = m_axi_arvalid && m_axi_arready;
  assign r_hs        = m_axi_rvalid && m_axi_rready;
  assign at_last_pos = (beat_q == len_q - 32'd1);
  assign fifo_pop    = word_tvalid && word_tready;

  assign ap_done    = done_q;
  assign busy       = busy_q;
  assign rlast_err  = rlast_err_q;
  assign word_tdata = fifo_dout;
  assign word_tlast = word_tvalid && (word_idx_q == total_q - 32'd1);

  // Burst length (request/burst/4KB limits) and FIFO credit; no beats are in flight while in ADDR.
  // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, addr_q[11:0]};
    words_to_4k = 32'(bytes_to_4k) >> 2;
    len_c       = min_u32(min_u32(words_left_q, 32'(C_BURST_LEN)), words_to_4k);
    free_slots  = 32'(C_FIFO_DEPTH) - 32'(fifo_count);
    credit_ok   = !fifo_full && (free_slots >= len_c);
  end

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; bursts are counted by beats, never by rlast.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = (instr_num == 32'd0) ? FIN : ADDR;
      ADDR:    if (ar_hs) state_d = DATA;
      DATA:    if (r_hs && at_last_pos) state_d = (words_left_q != 32'd0) ? ADDR : DRAIN;
      DRAIN:   if (fifo_pop && word_tlast) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; len and address only change on the AR handshake, so AR stays stable while waiting.
  always_comb begin
    m_axi_arvalid = (state_q == ADDR) && credit_ok;
    m_axi_araddr  = addr_q;
    m_axi_arlen   = 8'(len_c - 32'd1);
    m_axi_rready  = (state_q == DATA);
    word_tvalid   = !fifo_empty;
  end

  // Request bookkeeping, beat checking, output word index and handshake flags.
  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q       <= '0;
      words_left_q <= '0;
      total_q      <= '0;
      word_idx_q   <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rlast_err_q  <= 1'b0;
    end else begin
      done_q <= (state_q == FIN);
      if (start_acc)   busy_q <= 1'b1;
      else if (done_q) busy_q <= 1'b0;

      if (start_acc) begin
        addr_q       <= ctrl_addr_offset;
        words_left_q <= instr_num;
        total_q      <= instr_num;
        word_idx_q   <= '0;
        rlast_err_q  <= 1'b0;
      end else begin
        if (ar_hs) begin
          addr_q       <= addr_q + C_M_AXI_ADDR_WIDTH'({len_c, 2'b00});
          words_left_q <= words_left_q - len_c;
          len_q        <= len_c;
          beat_q       <= '0;
        end
        if (r_hs) begin
          beat_q <= beat_q + 32'd1;
          if (m_axi_rlast != at_last_pos) rlast_err_q <= 1'b1;
        end
        if (fifo_pop) word_idx_q <= word_idx_q + 32'd1;
      end
    end
  end

  pulpino_sync_fifo #(
    .WIDTH(32),
    .DEPTH(C_FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (aclk),
    .rst_i  (areset),
    .push_i (r_hs),
    .din_i  (m_axi_rdata[31:0]),
    .pop_i  (fifo_pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

endmodule
